// File: rtl/max_pool_2x2.sv
// max_pool_2x2
//   Non-overlapping 2x2 pooling of a valid-qualified pixel stream.
//   Even rows reduce each column pair into a half-row line buffer. Odd rows
//   combine their own column pair with the buffered entry and emit one
//   registered result per tile.
//
// Parameters
//   WORD_SIZE   pixel width in bits
//   ROW_SIZE    valid pixels per incoming row (an odd value drops the last column)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   inputPixel   unsigned pixel in, qualified by inputValid
//   inputValid   accept strobe; all state advances only when high
//   outputPixel  pooled pixel, registered, holds its value between strobes
//   valid        one-cycle strobe qualifying outputPixel
//
// Configuration
//   POOL_AVG_EN  when defined, average pooling replaces max pooling
module max_pool_2x2 #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ROW_SIZE  = 538
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inputValid,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 valid
);

  localparam int unsigned HALF = ROW_SIZE / 2;
  localparam int unsigned CW   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned IW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam bit          ROW_IS_ODD = (ROW_SIZE % 2) == 1;
  localparam logic [CW-1:0] LAST_COL = CW'(ROW_SIZE - 1);

`ifdef POOL_AVG_EN
  localparam int unsigned LBW = WORD_SIZE + 1;
`else
  localparam int unsigned LBW = WORD_SIZE;
`endif

  logic [CW-1:0]        col_q, col_d;
  logic                 row_odd_q, row_odd_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [WORD_SIZE-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic [LBW-1:0]       line_buf_q [HALF];

  logic                 col_last;
  logic                 in_pair;
  logic [IW-1:0]        lb_idx;
  logic [LBW-1:0]       lb_rd;
  logic                 lb_we;
  logic [LBW-1:0]       pair;
  logic [WORD_SIZE-1:0] result;

  assign col_last = (col_q == LAST_COL);
  // Only the trailing column of an odd-width row falls outside a pair.
  assign in_pair  = !(ROW_IS_ODD && col_last);
  assign lb_idx   = IW'(col_q >> 1);
  assign lb_rd    = line_buf_q[lb_idx];

`ifdef POOL_AVG_EN
  logic [WORD_SIZE+1:0] sum4;
  always_comb begin
    pair   = {1'b0, hold_q} + {1'b0, inputPixel};
    sum4   = {2'b00, hold_q} + {2'b00, inputPixel} + {1'b0, lb_rd};
    result = sum4[WORD_SIZE+1:2];
  end
`else
  always_comb begin
    pair   = (hold_q > inputPixel) ? hold_q : inputPixel;
    result = (pair > lb_rd) ? pair : lb_rd;
  end
`endif

  always_comb begin
    col_d     = col_q;
    row_odd_d = row_odd_q;
    hold_d    = hold_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    lb_we     = 1'b0;
    if (inputValid) begin
      col_d     = col_last ? '0 : col_q + CW'(1);
      row_odd_d = row_odd_q ^ col_last;
      if (in_pair) begin
        if (!col_q[0]) begin
          hold_d = inputPixel;
        end else if (!row_odd_q) begin
          lb_we = 1'b1;
        end else begin
          out_d   = result;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_odd_q <= 1'b0;
      hold_q    <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_odd_q <= row_odd_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  // Not reset: every entry is rewritten on the even row before it is read.
  always_ff @(posedge clk) begin
    if (!rst && lb_we) begin
      line_buf_q[lb_idx] <= pair;
    end
  end

  assign outputPixel = out_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       rst4, rst5;
  logic [7:0] in4, in5;
  logic       iv4, iv5;
  logic [7:0] out4, out5;
  logic       valid4, valid5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4)) u_dut4 (
    .clk(clk), .rst(rst4), .inputPixel(in4), .inputValid(iv4),
    .outputPixel(out4), .valid(valid4)
  );

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(5)) u_dut5 (
    .clk(clk), .rst(rst5), .inputPixel(in5), .inputValid(iv5),
    .outputPixel(out5), .valid(valid5)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected value for max mode or average mode, both worked out by hand.
  function automatic int pick(input int mx, input int av);
`ifdef POOL_AVG_EN
    return av;
`else
    return mx;
`endif
  endfunction

  // Present one pixel, let it be accepted, then check the strobe right after.
  task automatic accept(input int dut, input int pix, input int ev, input int eo,
                        input string tag);
    if (dut == 0) begin in4 = 8'(pix); iv4 = 1'b1; end
    else          begin in5 = 8'(pix); iv5 = 1'b1; end
    @(posedge clk); #1;
    iv4 = 1'b0;
    iv5 = 1'b0;
    if (dut == 0) begin
      check({tag, "_v"}, int'(valid4), ev);
      if (ev != 0) check({tag, "_o"}, int'(out4), eo);
    end else begin
      check({tag, "_v"}, int'(valid5), ev);
      if (ev != 0) check({tag, "_o"}, int'(out5), eo);
    end
  endtask

  task automatic idle4(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, "_idle_v"}, int'(valid4), 0);
    end
  endtask

  int gaps [8] = '{0, 3, 1, 5, 2, 0, 4, 1};

  initial begin
    rst4 = 1'b1; rst5 = 1'b1;
    in4 = '0; in5 = '0; iv4 = 1'b0; iv5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst4_v", int'(valid4), 0);
    check("rst4_o", int'(out4), 0);
    check("rst5_v", int'(valid5), 0);
    check("rst5_o", int'(out5), 0);
    rst4 = 1'b0; rst5 = 1'b0;

    // Continuous rows [1,2,3,4] [5,6,7,8]
    accept(0, 1, 0, 0, "t1"); accept(0, 2, 0, 0, "t1");
    accept(0, 3, 0, 0, "t1"); accept(0, 4, 0, 0, "t1");
    accept(0, 5, 0, 0, "t1"); accept(0, 6, 1, pick(6, 3), "t1_tile0");
    accept(0, 7, 0, 0, "t1"); accept(0, 8, 1, pick(8, 5), "t1_tile1");

    // Same rows with gaps between pixels
    for (int i = 0; i < 8; i++) begin
      idle4(gaps[i], "t2");
      if (i == 5)      accept(0, i + 1, 1, pick(6, 3), "t2_tile0");
      else if (i == 7) accept(0, i + 1, 1, pick(8, 5), "t2_tile1");
      else             accept(0, i + 1, 0, 0, "t2");
    end
    idle4(3, "t2_tail");

    // Four rows: line buffer rewritten per row pair, max in any position
    accept(0, 9, 0, 0, "t3");   accept(0, 0, 0, 0, "t3");
    accept(0, 0, 0, 0, "t3");   accept(0, 0, 0, 0, "t3");
    accept(0, 0, 0, 0, "t3");   accept(0, 0, 1, pick(9, 2), "t3_a");
    accept(0, 0, 0, 0, "t3");   accept(0, 3, 1, pick(3, 0), "t3_b");
    accept(0, 255, 0, 0, "t3"); accept(0, 1, 0, 0, "t3");
    accept(0, 2, 0, 0, "t3");   accept(0, 2, 0, 0, "t3");
    accept(0, 0, 0, 0, "t3");   accept(0, 0, 1, pick(255, 64), "t3_c");
    accept(0, 7, 0, 0, "t3");   accept(0, 1, 1, pick(7, 3), "t3_d");

    // Reset mid-row, with a pixel offered during reset
    accept(0, 10, 0, 0, "t4"); accept(0, 20, 0, 0, "t4"); accept(0, 30, 0, 0, "t4");
    rst4 = 1'b1; in4 = 8'd77; iv4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; iv4 = 1'b0;
    check("t4_rst_v", int'(valid4), 0);
    check("t4_rst_o", int'(out4), 0);
    for (int i = 0; i < 4; i++) accept(0, 1, 0, 0, "t4");
    accept(0, 2, 0, 0, "t4"); accept(0, 2, 1, pick(2, 1), "t4_a");
    accept(0, 2, 0, 0, "t4"); accept(0, 2, 1, pick(2, 1), "t4_b");
    idle4(2, "t4_tail");

    // Pooling edge values {1,2,5,6} and {255,255,255,255}
    accept(0, 1, 0, 0, "t6");   accept(0, 2, 0, 0, "t6");
    accept(0, 255, 0, 0, "t6"); accept(0, 255, 0, 0, "t6");
    accept(0, 5, 0, 0, "t6");   accept(0, 6, 1, pick(6, 3), "t6_a");
    accept(0, 255, 0, 0, "t6"); accept(0, 255, 1, 255, "t6_b");

    // Odd row width: trailing 99 discarded
    accept(1, 1, 0, 0, "t5"); accept(1, 2, 0, 0, "t5");
    accept(1, 3, 0, 0, "t5"); accept(1, 4, 0, 0, "t5");
    accept(1, 99, 0, 0, "t5");
    accept(1, 5, 0, 0, "t5"); accept(1, 6, 1, pick(6, 3), "t5_a");
    accept(1, 7, 0, 0, "t5"); accept(1, 8, 1, pick(8, 5), "t5_b");
    accept(1, 99, 0, 0, "t5_drop");
    check("t5_hold_o", int'(out5), pick(8, 5));
    // Next row must start fresh at column 0
    accept(1, 3, 0, 0, "t5"); accept(1, 1, 0, 0, "t5");
    accept(1, 0, 0, 0, "t5"); accept(1, 0, 0, 0, "t5");
    accept(1, 99, 0, 0, "t5");
    accept(1, 0, 0, 0, "t5"); accept(1, 2, 1, pick(3, 1), "t5_c");
    accept(1, 4, 0, 0, "t5"); accept(1, 0, 1, pick(4, 1), "t5_d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
